main_memory: RTL and testbench
==============================

# main_memory

Byte-addressable, single-port main memory for the 8-bit processor: 256 locations of 8 bits with one synchronous write port and one combinational read port, sharing a single address bus. It sits between the datapath (address and data buses) and the control unit (memRead and memWrite strobes). It serves as unified instruction/data storage.

## Interface
Parameters:
- ADDR_WIDTH, default 8: address bus width; depth = 2^ADDR_WIDTH.
- DATA_WIDTH, default 8: word width.

Ports:
- clk  input  1  system clock; all state changes occur on the rising edge.
- reset  input  1  synchronous, active-high reset.
- address  input  ADDR_WIDTH  location for both read and write.
- dataIn  input  DATA_WIDTH  write data.
- memWrite  input  1  write enable, sampled at the rising clk edge.
- memRead  input  1  read enable, combinational.
- dataOut  output  DATA_WIDTH  read data.

One clock; reset is synchronous and active-high.

## Operation
- Storage: array of 2^ADDR_WIDTH words, each DATA_WIDTH bits; there is no additional state.
- Reset: at a rising edge with reset=1, every location is cleared to 0. Reset has priority over memWrite, so no write occurs in that cycle.
- Write: at a rising edge with reset=0 and memWrite=1, mem[address] <= dataIn. With memWrite=0, contents are held.
- Read: dataOut = mem[address] when memRead=1, otherwise dataOut = 0. The read path is purely combinational.
- memRead and memWrite both high is legal:
  - The write occurs at the edge.
  - Before the edge, dataOut shows the old contents.
  - After the edge, dataOut shows the new contents.
- The full address range is valid, with no wrap or out-of-range case because depth is exactly 2^ADDR_WIDTH.
- Unknown (X/Z) address or enable values need not be handled.

## Timing
- Write latency: 1 edge; the written data is visible on dataOut immediately after that edge if memRead=1 and the address is unchanged.
- Read latency: 0 cycles; dataOut follows address and memRead combinationally.
- Reset value of dataOut:
  - 0 after the first reset edge, because all locations are 0.
  - 0 whenever memRead=0.
- Reset asserted mid-operation:
  - The clear takes effect at the next rising edge, and contents are lost.
  - Any memWrite in that cycle is ignored.
- Before the first reset, contents are undefined. The bench must reset before checking.
- Inputs changing between edges do not affect stored contents; only values at the edge matter.

## Structure
- Shared package mem_pkg holds:
  - ADDR_WIDTH and DATA_WIDTH defaults (8/8).
  - Derived MEM_DEPTH = 2^ADDR_WIDTH.
  - The word and address types.
- One sub-module is natural: mem_array, holding the register array with synchronous clear and write plus the asynchronous read.
- The top level adds the memRead output gating.
- Implement with registers, not inferred block RAM, because of the synchronous whole-array clear.

## Test plan
- Reset:
  - Stimulus: reset=1 for one edge, then memRead=1 and sweep addresses 0..255.
  - Required: dataOut=0 at every address.
- Write/read-back:
  - Stimulus: memWrite=1, address=0, dataIn=196 at one edge; then address=1, dataIn=127 at the next edge; then memWrite=0.
  - Required: with memRead=1, address=0 gives dataOut=196 and address=1 gives dataOut=127.
- Read gating:
  - Stimulus: memRead=0 at address 0 after the writes above.
  - Required: dataOut=0. Raising memRead gives dataOut=196 in the same cycle, with no edge needed.
- Write with memRead=1 at the same address:
  - Stimulus: address=5 holding 0, dataIn=0xAA, memWrite=1.
  - Required: dataOut=0 before the edge and 0xAA after the edge.
- Reset priority:
  - Stimulus: reset=1 and memWrite=1 with address=1, dataIn=55 at the same edge.
  - Required: afterwards address=1 reads 0 and address=0 reads 0.
- Hold:
  - Stimulus: memWrite=0 while dataIn toggles across 10 edges.
  - Required: stored values unchanged, e.g. address 1 still reads 127.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the processor main memory: default widths,
// derived depth and the word/address types.
package mem_pkg;

   localparam int ADDR_WIDTH = 8;
   localparam int DATA_WIDTH = 8;
   localparam int MEM_DEPTH  = 1 << ADDR_WIDTH;

   typedef logic [DATA_WIDTH-1:0] word_t;
   typedef logic [ADDR_WIDTH-1:0] addr_t;

endpackage

// File: rtl/main_memory_if.sv
// Memory bus between the datapath/control unit (master) and the memory (slave).
interface main_memory_if #(
   parameter int ADDR_WIDTH = mem_pkg::ADDR_WIDTH,
   parameter int DATA_WIDTH = mem_pkg::DATA_WIDTH
);

   logic [ADDR_WIDTH-1:0] address;
   logic [DATA_WIDTH-1:0] dataIn;
   logic                  memWrite;
   logic                  memRead;
   logic [DATA_WIDTH-1:0] dataOut;

   modport master (
      output address,
      output dataIn,
      output memWrite,
      output memRead,
      input  dataOut
   );

   modport slave (
      input  address,
      input  dataIn,
      input  memWrite,
      input  memRead,
      output dataOut
   );

endinterface

// File: rtl/main_memory_mem_array.sv
// Register-based storage array: synchronous whole-array clear, synchronous
// single-word write and an asynchronous (combinational) read.
// Built from flops rather than block RAM because the clear touches every word
// in one edge.
module mem_array #(
   parameter int ADDR_WIDTH = mem_pkg::ADDR_WIDTH,
   parameter int DATA_WIDTH = mem_pkg::DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [DATA_WIDTH-1:0] dataIn,
   input  logic                  memWrite,
   output logic [DATA_WIDTH-1:0] rd_data
);

   import mem_pkg::*;

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [DEPTH];

   // Next-state of the array: hold everything, overwrite the addressed word on a write.
   always_comb begin
      mem_d = mem_q;
      if (memWrite) begin
         mem_d[address] = dataIn;
      end
   end

   // Register the array; reset clears every word and wins over any write.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_q <= '{default: '0};
      end else begin
         mem_q <= mem_d;
      end
   end

   // Read port is purely combinational; the address range exactly matches the depth.
   always_comb begin
      rd_data = mem_q[address];
   end

endmodule

// File: rtl/main_memory.sv
// Unified instruction/data main memory for the 8-bit processor.
// Wraps the storage array and gates the read data with memRead so the
// output bus is zero whenever no read is requested.
module main_memory #(
   parameter int ADDR_WIDTH = mem_pkg::ADDR_WIDTH,
   parameter int DATA_WIDTH = mem_pkg::DATA_WIDTH
) (
   input  logic          clk,
   input  logic          reset,
   main_memory_if.slave  bus
);

   import mem_pkg::*;

   logic [DATA_WIDTH-1:0] rd_data;

   mem_array #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_mem_array (
      .clk      (clk),
      .reset    (reset),
      .address  (bus.address),
      .dataIn   (bus.dataIn),
      .memWrite (bus.memWrite),
      .rd_data  (rd_data)
   );

   // Output gating: the stored word appears only while memRead is high.
   always_comb begin
      bus.dataOut = bus.memRead ? rd_data : '0;
   end

endmodule

// File: tb/tb_main_memory.sv
// Directed testbench for main_memory: reset sweep, write/read-back, read
// gating, write-through visibility, reset priority and hold.
module tb_main_memory;

   logic clk;
   logic reset;

   int checks;
   int errors;

   main_memory_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();

   main_memory #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against its expected value.
   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks = checks + 1;
      if (got !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance past the next rising edge and settle.
   task automatic edge_step();
      @(posedge clk);
      #1;
   endtask

   // Set address/memRead and read the combinational output.
   task automatic rd(input logic [7:0] a, input string tag, input logic [7:0] exp);
      bus.address = a;
      bus.memRead = 1'b1;
      #1;
      chk(tag, bus.dataOut, exp);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      checks       = 0;
      errors       = 0;
      reset        = 1'b0;
      bus.address  = '0;
      bus.dataIn   = '0;
      bus.memWrite = 1'b0;
      bus.memRead  = 1'b0;
      #2;

      // Reset sweep: every location reads zero.
      reset = 1'b1;
      edge_step();
      reset = 1'b0;
      for (int i = 0; i < 256; i++) begin
         rd(8'(i), "reset_sweep", 8'd0);
      end

      // Write two locations, then read them back.
      bus.memWrite = 1'b1;
      bus.address  = 8'd0;
      bus.dataIn   = 8'd196;
      edge_step();
      bus.address  = 8'd1;
      bus.dataIn   = 8'd127;
      edge_step();
      bus.memWrite = 1'b0;
      rd(8'd0, "readback_a0", 8'd196);
      rd(8'd1, "readback_a1", 8'd127);
      rd(8'd2, "readback_a2", 8'd0);

      // Read gating: memRead low forces zero, raising it shows data without an edge.
      bus.address = 8'd0;
      bus.memRead = 1'b0;
      #1;
      chk("gate_off", bus.dataOut, 8'd0);
      bus.memRead = 1'b1;
      #1;
      chk("gate_on", bus.dataOut, 8'd196);

      // Write with memRead high at the same address: old data before, new after.
      bus.address  = 8'd5;
      bus.dataIn   = 8'hAA;
      bus.memWrite = 1'b1;
      bus.memRead  = 1'b1;
      #1;
      chk("wr_before_edge", bus.dataOut, 8'd0);
      edge_step();
      chk("wr_after_edge", bus.dataOut, 8'hAA);
      bus.memWrite = 1'b0;

      // Hold: dataIn toggles across 10 edges with memWrite low.
      bus.address = 8'd1;
      for (int k = 0; k < 10; k++) begin
         bus.dataIn = (k % 2 == 0) ? 8'hFF : 8'h00;
         edge_step();
      end
      rd(8'd1, "hold_a1", 8'd127);
      rd(8'd0, "hold_a0", 8'd196);
      rd(8'd5, "hold_a5", 8'hAA);

      // Reset priority over a simultaneous write.
      bus.address  = 8'd1;
      bus.dataIn   = 8'd55;
      bus.memWrite = 1'b1;
      reset        = 1'b1;
      edge_step();
      reset        = 1'b0;
      bus.memWrite = 1'b0;
      rd(8'd1, "rstprio_a1", 8'd0);
      rd(8'd0, "rstprio_a0", 8'd0);
      rd(8'd5, "rstprio_a5", 8'd0);

      // Top and bottom of the address range after reset.
      bus.memWrite = 1'b1;
      bus.address  = 8'd255;
      bus.dataIn   = 8'h5A;
      edge_step();
      bus.memWrite = 1'b0;
      rd(8'd255, "top_addr", 8'h5A);
      rd(8'd0, "bottom_addr", 8'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
